pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/pipe_scoreboard.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the ID/WB hazard controller and its scoreboard.
package pipe_ctrl_pkg;
  localparam int REG_W         = 3;
  localparam int NREGS         = 1 << REG_W;
  localparam int CNT_W         = 3;
  localparam int MULTI_LAT_DEF = 3;

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } state_e;
endpackage

// File: rtl/pipe_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on multi-op
// issue, cleared wholesale when the multi-cycle result writes back.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_all,
  input  logic [REG_W-1:0] look_a,
  input  logic [REG_W-1:0] look_b,
  input  logic [REG_W-1:0] look_d,
  output logic             hit_a,
  output logic             hit_b,
  output logic             hit_d
);
  logic [NREGS-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_all) pend_d = '0;
    if (set_en)  pend_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign hit_a = pend_q[look_a];
  assign hit_b = pend_q[look_b];
  assign hit_d = pend_q[look_d];
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Issue/stall/forward control for a two-stage ID->WB pipe with one
// multi-cycle unit sharing the WB slot.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULTI_LAT = MULTI_LAT_DEF
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src_a,
  input  logic [REG_W-1:0] id_src_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [REG_W-1:0] id_rdst,
  input  logic             id_wr,
  input  logic             id_multi,
  input  logic             flush_req,
  output logic             id_stall,
  output logic             pipe_en,
  output logic             pipe_flush,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             wb_valid,
  output logic             wb_wr,
  output logic [REG_W-1:0] wb_rdst,
  output logic             multi_wb,
  output logic             busy
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wb_valid_q, wb_valid_d;
  logic             wb_wr_q, wb_wr_d;
  logic [REG_W-1:0] wb_rdst_q, wb_rdst_d;
  logic             multi_wb_q, multi_wb_d;
  logic             hit_a, hit_b, hit_d;
  logic             sb_set, sb_clr;
  logic             in_multi, last_cyc, raw, waw, stall, accept, issue_single;

  pipe_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (sb_set),
    .set_idx (id_rdst),
    .clr_all (sb_clr),
    .look_a  (id_src_a),
    .look_b  (id_src_b),
    .look_d  (id_rdst),
    .hit_a   (hit_a),
    .hit_b   (hit_b),
    .hit_d   (hit_d)
  );

  // Final multi cycle owns the next WB slot, so single-cycle ops must wait.
  always_comb begin
    in_multi     = (state_q == MULTI);
    last_cyc     = in_multi && (cnt_q == '0);
    raw          = (id_use_a & hit_a) | (id_use_b & hit_b);
    waw          = id_wr & hit_d;
    stall        = id_valid & (raw | waw | (id_multi & in_multi) | (~id_multi & last_cyc));
    accept       = id_valid & ~stall & ~flush_req;
    issue_single = accept & ~id_multi;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sb_set     = 1'b0;
    sb_clr     = 1'b0;
    multi_wb_d = 1'b0;
    case (state_q)
      RUN: begin
        if (accept && id_multi) begin
          state_d = MULTI;
          cnt_d   = CNT_W'(MULTI_LAT - 1);
          sb_set  = id_wr;
        end
      end
      MULTI: begin
        if (cnt_q == '0) begin
          state_d    = RUN;
          sb_clr     = 1'b1;
          multi_wb_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    wb_valid_d = issue_single;
    wb_wr_d    = issue_single & id_wr;
    wb_rdst_d  = issue_single ? id_rdst : wb_rdst_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_wr_q    <= 1'b0;
      wb_rdst_q  <= '0;
      multi_wb_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_wr_q    <= wb_wr_d;
      wb_rdst_q  <= wb_rdst_d;
      multi_wb_q <= multi_wb_d;
    end
  end

  assign id_stall   = stall;
  assign pipe_flush = flush_req;
  assign pipe_en    = accept | flush_req;
  assign fwd_a      = id_use_a & wb_valid_q & wb_wr_q & (wb_rdst_q == id_src_a);
  assign fwd_b      = id_use_b & wb_valid_q & wb_wr_q & (wb_rdst_q == id_src_b);
  assign wb_valid   = wb_valid_q;
  assign wb_wr      = wb_wr_q;
  assign wb_rdst    = wb_rdst_q;
  assign multi_wb   = multi_wb_q;
  assign busy       = in_multi;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with MULTI_LAT = 3.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_a, id_use_b, id_wr, id_multi, flush_req;
  logic [2:0] id_src_a, id_src_b, id_rdst;
  logic       id_stall, pipe_en, pipe_flush, fwd_a, fwd_b;
  logic       wb_valid, wb_wr, multi_wb, busy;
  logic [2:0] wb_rdst;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULTI_LAT(3)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b),
    .id_rdst(id_rdst), .id_wr(id_wr), .id_multi(id_multi),
    .flush_req(flush_req), .id_stall(id_stall), .pipe_en(pipe_en),
    .pipe_flush(pipe_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .wb_valid(wb_valid), .wb_wr(wb_wr), .wb_rdst(wb_rdst),
    .multi_wb(multi_wb), .busy(busy)
  );

  task automatic drive(input logic v, input logic [2:0] a, input logic ua,
                       input logic [2:0] b, input logic ub,
                       input logic [2:0] rd, input logic wr, input logic mu);
    id_valid = v; id_src_a = a; id_use_a = ua; id_src_b = b; id_use_b = ub;
    id_rdst = rd; id_wr = wr; id_multi = mu; flush_req = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%0b want=0", wb_valid); end
    total++; if (wb_wr !== 1'b0) begin bad++; $display("FAIL rst_wb_wr got=%0b want=0", wb_wr); end
    total++; if (wb_rdst !== 3'd0) begin bad++; $display("FAIL rst_wb_rdst got=%0d want=0", wb_rdst); end
    total++; if (multi_wb !== 1'b0) begin bad++; $display("FAIL rst_multi_wb got=%0b want=0", multi_wb); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b want=0", id_stall); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    #1;
    total++; if (id_stall !== 1'b0 || pipe_en !== 1'b1) begin bad++; $display("FAIL b2b_issue1 stall=%0b en=%0b want stall=0 en=1", id_stall, pipe_en); end
    tick();
    total++; if (wb_valid !== 1'b1 || wb_wr !== 1'b1 || wb_rdst !== 3'd1) begin bad++; $display("FAIL b2b_wb1 got v=%0b w=%0b rd=%0d want 1 1 1", wb_valid, wb_wr, wb_rdst); end
    drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 1'b0);
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL b2b_stall2 got=%0b want=0", id_stall); end
    total++; if (fwd_a !== 1'b1 || fwd_b !== 1'b0) begin bad++; $display("FAIL b2b_fwd got a=%0b b=%0b want a=1 b=0", fwd_a, fwd_b); end
    tick();
    total++; if (wb_rdst !== 3'd2 || wb_valid !== 1'b1) begin bad++; $display("FAIL b2b_wb2 got rd=%0d v=%0b want rd=2 v=1", wb_rdst, wb_valid); end
    // reader of r2 with use_a cleared must not forward
    drive(1'b1, 3'd2, 1'b0, 3'd2, 1'b1, 3'd4, 1'b0, 1'b0);
    #1;
    total++; if (fwd_a !== 1'b0 || fwd_b !== 1'b1) begin bad++; $display("FAIL b2b_fwd_use got a=%0b b=%0b want a=0 b=1", fwd_a, fwd_b); end
    tick();
    total++; if (wb_valid !== 1'b1 || wb_wr !== 1'b0) begin bad++; $display("FAIL b2b_nowr got v=%0b w=%0b want v=1 w=0", wb_valid, wb_wr); end
    idle();
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble got=%0b want=0", wb_valid); end
  endtask

  task automatic test_multi_raw();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
    #1;
    total++; if (id_stall !== 1'b0 || pipe_en !== 1'b1) begin bad++; $display("FAIL mraw_issue stall=%0b en=%0b want 0 1", id_stall, pipe_en); end
    tick();
    total++; if (busy !== 1'b1 || wb_valid !== 1'b0) begin bad++; $display("FAIL mraw_busy got busy=%0b wbv=%0b want 1 0", busy, wb_valid); end
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (id_stall !== 1'b1 || pipe_en !== 1'b0) begin bad++; $display("FAIL mraw_stall_c%0d stall=%0b en=%0b want 1 0", i + 1, id_stall, pipe_en); end
      total++; if (multi_wb !== 1'b0) begin bad++; $display("FAIL mraw_early_wb_c%0d got=%0b want=0", i + 1, multi_wb); end
      tick();
    end
    total++; if (multi_wb !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mraw_wb got mwb=%0b busy=%0b want 1 0", multi_wb, busy); end
    total++; if (id_stall !== 1'b0 || pipe_en !== 1'b1) begin bad++; $display("FAIL mraw_accept stall=%0b en=%0b want 0 1", id_stall, pipe_en); end
    tick();
    total++; if (multi_wb !== 1'b0 || wb_valid !== 1'b1 || wb_rdst !== 3'd4) begin bad++; $display("FAIL mraw_after mwb=%0b v=%0b rd=%0d want 0 1 4", multi_wb, wb_valid, wb_rdst); end
    idle();
    tick();
  endtask

  task automatic test_multi_indep();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL mind_c1 got=%0b want=0", id_stall); end
    tick();
    total++; if (wb_valid !== 1'b1 || wb_rdst !== 3'd5) begin bad++; $display("FAIL mind_wb5 v=%0b rd=%0d want 1 5", wb_valid, wb_rdst); end
    drive(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
    #1;
    total++; if (id_stall !== 1'b0 || fwd_a !== 1'b1) begin bad++; $display("FAIL mind_c2 stall=%0b fwd_a=%0b want 0 1", id_stall, fwd_a); end
    tick();
    total++; if (wb_rdst !== 3'd6) begin bad++; $display("FAIL mind_wb6 got=%0d want=6", wb_rdst); end
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0);
    #1;
    total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL mind_slot got=%0b want=1", id_stall); end
    tick();
    total++; if (multi_wb !== 1'b1 || wb_valid !== 1'b0) begin bad++; $display("FAIL mind_mwb mwb=%0b v=%0b want 1 0", multi_wb, wb_valid); end
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL mind_run got=%0b want=0", id_stall); end
    tick();
    total++; if (wb_valid !== 1'b1 || wb_rdst !== 3'd7) begin bad++; $display("FAIL mind_wb7 v=%0b rd=%0d want 1 7", wb_valid, wb_rdst); end
    idle();
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    flush_req = 1'b1;
    #1;
    total++; if (pipe_flush !== 1'b1 || pipe_en !== 1'b1) begin bad++; $display("FAIL fl_out flush=%0b en=%0b want 1 1", pipe_flush, pipe_en); end
    tick();
    total++; if (wb_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL fl_next wbv=%0b busy=%0b want 0 1", wb_valid, busy); end
    flush_req = 1'b0;
    #1;
    total++; if (id_stall !== 1'b1 || pipe_flush !== 1'b0) begin bad++; $display("FAIL fl_pend stall=%0b flush=%0b want 1 0", id_stall, pipe_flush); end
    tick();
    tick();
    total++; if (multi_wb !== 1'b1) begin bad++; $display("FAIL fl_mwb got=%0b want=1", multi_wb); end
    // flushing an unstalled instruction must also suppress its accept
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
    flush_req = 1'b1;
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL fl_noacc got=%0b want=0", wb_valid); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_multi();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
    tick();
    idle();
    #2 reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || multi_wb !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL rmid_async busy=%0b mwb=%0b wbv=%0b want 0 0 0", busy, multi_wb, wb_valid); end
    #1 reset = 1'b1;
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL rmid_pending got=%0b want=0", id_stall); end
    tick();
    total++; if (wb_valid !== 1'b1 || wb_rdst !== 3'd3) begin bad++; $display("FAIL rmid_issue v=%0b rd=%0d want 1 3", wb_valid, wb_rdst); end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (multi_wb !== 1'b0) begin bad++; $display("FAIL rmid_ghost_c%0d got=%0b want=0", i, multi_wb); end
    end
  endtask

  task automatic test_multi_multi();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    #1;
    total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL mm_waw got=%0b want=1", id_stall); end
    id_valid = 1'b0;
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL mm_novalid got=%0b want=0", id_stall); end
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL mm_stall_c%0d got=%0b want=1", i + 1, id_stall); end
      tick();
    end
    total++; if (multi_wb !== 1'b1 || id_stall !== 1'b0 || pipe_en !== 1'b1) begin bad++; $display("FAIL mm_accept mwb=%0b stall=%0b en=%0b want 1 0 1", multi_wb, id_stall, pipe_en); end
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mm_busy got=%0b want=1", busy); end
    drive(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0);
    #1;
    total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL mm_raw_r2 got=%0b want=1", id_stall); end
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL mm_r3_free got=%0b want=0", id_stall); end
    idle();
    tick();
    tick();
    tick();
    total++; if (multi_wb !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mm_wb2 mwb=%0b busy=%0b want 1 0", multi_wb, busy); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_multi_raw();
    test_multi_indep();
    test_flush();
    test_reset_mid_multi();
    test_multi_multi();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
